// File: rtl/img_mem_arbiter_pkg.sv
// Shared types for the BMP image RAM arbiter.
//   arb_state_t : load/commit sequencer states
//   rgb888_t    : one RGB888 pixel as stored in the image RAM
package img_mem_pkg;

  localparam int unsigned PIX_W   = 24;
  localparam int unsigned COORD_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

endpackage

// File: rtl/img_mem_arbiter_if.sv
// Loader write stream plus single-port RAM bus.
//   master : arbiter side (accepts loader pixels, drives the RAM)
//   slave  : environment side (loader source and RAM)
interface img_mem_arbiter_if
  import img_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 19
) ();

  logic              wr_valid;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata;

  modport master (
    input  wr_valid, wr_data, mem_rdata,
    output wr_ready, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output wr_valid, wr_data, mem_rdata,
    input  wr_ready, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/img_mem_arbiter_rd_pipe.sv
// Read-return alignment: delays {rd_en, DE} by MEM_LAT cycles to meet the
// RAM data, then registers RGB and DE together.
//   clk, rst_n : clock, async active-low reset
//   rd_en, de  : display read strobe and raw DE for the current pixel
//   rdata      : RAM read data (valid MEM_LAT cycles after its address)
//   rgb, de_out: registered pixel (black when no read was issued) and DE
module img_rd_pipe
  import img_mem_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    rd_en,
  input  logic    de,
  input  rgb888_t rdata,
  output rgb888_t rgb,
  output logic    de_out
);

  logic [MEM_LAT-1:0] rd_sr;
  logic [MEM_LAT-1:0] de_sr;

  // Shift in at bit 0; the cast drops the oldest bit and also covers MEM_LAT=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sr  <= '0;
      de_sr  <= '0;
      rgb    <= '0;
      de_out <= 1'b0;
    end else begin
      rd_sr  <= MEM_LAT'({rd_sr, rd_en});
      de_sr  <= MEM_LAT'({de_sr, de});
      rgb    <= rd_sr[MEM_LAT-1] ? rdata : '0;
      de_out <= de_sr[MEM_LAT-1];
    end
  end

endmodule

// File: rtl/img_mem_arbiter.sv
// Single-port image RAM controller for the VGA pixel path.
// Display reads have strict priority over the loader write stream; a newly
// loaded image is committed for display only at a frame start.
//   clk, rst_n        : pixel clock, async active-low reset
//   DE, x, y          : VGA timing (display enable, column, row)
//   frame_start       : 1-cycle pulse at the first cycle of a frame
//   load_start        : 1-cycle pulse starting a new image load
//   bus (master)      : loader stream (wr_valid/wr_data/wr_ready) and RAM bus
//   r/g/b_port, de_out: pixel output, MEM_LAT+1 cycles after x/y/DE
//   busy              : sequencer not idle
//   img_valid         : a complete image is committed for display
module img_mem_arbiter
  import img_mem_pkg::*;
#(
  parameter int unsigned H_SIZE          = 640,
  parameter int unsigned V_SIZE          = 480,
  parameter int unsigned MEM_LAT         = 1,
  parameter int unsigned SHOW_WHILE_LOAD = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               DE,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               frame_start,
  input  logic               load_start,
  img_mem_arbiter_if.master  bus,
  output logic [7:0]         r_port,
  output logic [7:0]         g_port,
  output logic [7:0]         b_port,
  output logic               de_out,
  output logic               busy,
  output logic               img_valid
);

  localparam int unsigned NPIX   = H_SIZE * V_SIZE;
  localparam int unsigned ADDR_W = $clog2(NPIX);
  localparam int unsigned CALC_W = ADDR_W + COORD_W + 1;
  localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(H_SIZE);
  localparam logic [COORD_W:0] V_LIM = (COORD_W+1)'(V_SIZE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  arb_state_t        state;
  logic [ADDR_W-1:0] wr_addr;
  logic              disp_slot;
  logic              rd_en;
  logic              wr_fire;
  logic [CALC_W-1:0] rd_addr_full;
  rgb888_t           rdata;
  rgb888_t           rgb;

  // Display window and raster read address.
  assign disp_slot    = DE && ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
  assign rd_en        = disp_slot && img_valid;
  assign rd_addr_full = CALC_W'(y) * CALC_W'(H_SIZE) + CALC_W'(x);

  // Display always wins the RAM; the loader only gets free slots in ST_LOAD.
  assign bus.wr_ready  = (state == ST_LOAD) && !rd_en;
  assign wr_fire       = bus.wr_valid && bus.wr_ready;
  assign bus.mem_we    = wr_fire;
  assign bus.mem_wdata = bus.wr_data;
  assign bus.mem_addr  = rd_en ? ADDR_W'(rd_addr_full) : wr_addr;

  assign busy = (state != ST_IDLE);

  // Load sequencer: idle -> load (raster writes) -> wait for frame start -> idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wr_addr   <= '0;
      img_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_start) begin
            state   <= ST_LOAD;
            wr_addr <= '0;
            if (SHOW_WHILE_LOAD == 0) img_valid <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (wr_fire) begin
            if (wr_addr == LAST_ADDR) begin
              state   <= ST_COMMIT;
              wr_addr <= '0;
            end else begin
              wr_addr <= wr_addr + ADDR_W'(1);
            end
          end
        end
        ST_COMMIT: begin
          if (frame_start) begin
            state     <= ST_IDLE;
            img_valid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rdata = rgb888_t'(bus.mem_rdata);

  img_rd_pipe #(.MEM_LAT(MEM_LAT)) u_rd_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_en  (rd_en),
    .de     (DE),
    .rdata  (rdata),
    .rgb    (rgb),
    .de_out (de_out)
  );

  assign r_port = rgb.r;
  assign g_port = rgb.g;
  assign b_port = rgb.b;

endmodule
